// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - CPU data-memory controller: loads, stores, sub-word read-modify-write
// Optional misaligned-access trap enabled by defining MISALIGN_TRAP_EN.
module data_mem_ctrl #(
    parameter int ADDR_W = 13
) (
    input  logic              clka,
    input  logic              rsta_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        RD_WAIT = 3'd2,
        WR      = 3'd3,
        RESP    = 3'd4
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    state_t            r_state;
    logic              r_req_ready;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [1:0]        r_lane;
    logic [15:0]       r_wdata;
    logic              r_rsp_valid;
    logic [31:0]       r_rsp_rdata;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_din;

    logic              w_req_misalign;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load_data;
    logic [31:0]       w_merge_data;

`ifdef MISALIGN_TRAP_EN
    logic r_rsp_err;
    assign w_req_misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                            (req_size[1] && (req_addr[1:0] != 2'b00));
    assign rsp_err        = r_rsp_err;
`else
    assign w_req_misalign = 1'b0;
    assign rsp_err        = 1'b0;
`endif

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_din   = r_mem_din;

    // Lane extraction for loads, little-endian byte/half selection
    always_comb begin
        w_byte = 8'h00;
        case (r_lane)
            2'd0:    w_byte = mem_dout[7:0];
            2'd1:    w_byte = mem_dout[15:8];
            2'd2:    w_byte = mem_dout[23:16];
            default: w_byte = mem_dout[31:24];
        endcase
        w_half      = r_lane[1] ? mem_dout[31:16] : mem_dout[15:0];
        w_load_data = mem_dout;
        if (r_size == SZ_BYTE) begin
            w_load_data = {{24{r_signed & w_byte[7]}}, w_byte};
        end else if (r_size == SZ_HALF) begin
            w_load_data = {{16{r_signed & w_half[15]}}, w_half};
        end
    end

    // Sub-word store merge: replace only the addressed lane(s) of the read word
    always_comb begin
        w_merge_data = mem_dout;
        if (r_size == SZ_BYTE) begin
            case (r_lane)
                2'd0:    w_merge_data[7:0]   = r_wdata[7:0];
                2'd1:    w_merge_data[15:8]  = r_wdata[7:0];
                2'd2:    w_merge_data[23:16] = r_wdata[7:0];
                default: w_merge_data[31:24] = r_wdata[7:0];
            endcase
        end else if (r_lane[1]) begin
            w_merge_data[31:16] = r_wdata;
        end else begin
            w_merge_data[15:0] = r_wdata;
        end
    end

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
            r_we        <= 1'b0;
            r_size      <= 2'b00;
            r_signed    <= 1'b0;
            r_lane      <= 2'b00;
            r_wdata     <= 16'h0000;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0000_0000;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_din   <= 32'h0000_0000;
`ifdef MISALIGN_TRAP_EN
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_req_ready <= 1'b1;
                    if (req_valid) begin
                        r_req_ready <= 1'b0;
                        r_we        <= req_we;
                        r_size      <= req_size;
                        r_signed    <= req_signed;
                        r_lane      <= req_addr[1:0];
                        r_wdata     <= req_wdata[15:0];
                        if (w_req_misalign) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= 32'h0000_0000;
`ifdef MISALIGN_TRAP_EN
                            r_rsp_err   <= 1'b1;
`endif
                        end else if (req_we && req_size[1]) begin
                            r_state    <= WR;
                            r_mem_en   <= 1'b1;
                            r_mem_we   <= 1'b1;
                            r_mem_addr <= req_addr[ADDR_W+1:2];
                            r_mem_din  <= req_wdata;
                        end else begin
                            r_state    <= RD;
                            r_mem_en   <= 1'b1;
                            r_mem_addr <= req_addr[ADDR_W+1:2];
                        end
                    end
                end
                RD: begin
                    r_state <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (r_we) begin
                        r_state   <= WR;
                        r_mem_en  <= 1'b1;
                        r_mem_we  <= 1'b1;
                        r_mem_din <= w_merge_data;
                    end else begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= w_load_data;
`ifdef MISALIGN_TRAP_EN
                        r_rsp_err   <= 1'b0;
`endif
                    end
                end
                WR: begin
                    r_state     <= RESP;
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= 32'h0000_0000;
`ifdef MISALIGN_TRAP_EN
                    r_rsp_err   <= 1'b0;
`endif
                end
                RESP: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - randomized self-checking bench for data_mem_ctrl against a word-array model
module tb_data_mem_ctrl;

    localparam int ADDR_W = 13;
    localparam int NWORDS = 64;

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic              clka = 1'b0;
    logic              rsta_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W+1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_din;
    logic [31:0]       mem_dout;

    logic              init_en;
    logic [5:0]        init_addr;
    logic [31:0]       init_data;

    logic [31:0] ram   [0:(1<<ADDR_W)-1];
    logic [31:0] model [0:NWORDS-1];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clka = ~clka;

    data_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clka(clka), .rsta_n(rsta_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // Single-port RAM, one-cycle read latency
    always @(posedge clka) begin
        if (init_en) begin
            ram[{{(ADDR_W-6){1'b0}}, init_addr}] <= init_data;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_din;
            mem_dout <= ram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic run_req(input bit we, input logic [1:0] size, input bit sgn,
                           input int addr, input logic [31:0] wdata);
        int          w;
        int          sh;
        int          exp_lat, exp_en, exp_we;
        logic [31:0] mask, v, exp_rd;
        bit          misal, exp_err, got;
        int          lat, en_cnt, we_cnt;

        w       = addr / 4;
        misal   = TRAP && (((size == 2'b01) && (addr % 2 != 0)) ||
                           ((size >= 2'b10) && (addr % 4 != 0)));
        mask    = (size == 2'b00) ? 32'hFF : (size == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
        sh      = (size == 2'b00) ? 8 * (addr % 4) : (size == 2'b01) ? 16 * ((addr / 2) % 2) : 0;
        exp_rd  = 32'h0;
        exp_err = 1'b0;
        if (misal) begin
            exp_lat = 1; exp_en = 0; exp_we = 0; exp_err = 1'b1;
        end else if (we) begin
            if (size >= 2'b10) begin
                model[w] = wdata;
                exp_lat = 2; exp_en = 1; exp_we = 1;
            end else begin
                model[w] = (model[w] & ~(mask << sh)) | ((wdata & mask) << sh);
                exp_lat = 4; exp_en = 2; exp_we = 1;
            end
        end else begin
            v = (model[w] >> sh) & mask;
            if (sgn && size == 2'b00 && v[7])  v = v | 32'hFFFF_FF00;
            if (sgn && size == 2'b01 && v[15]) v = v | 32'hFFFF_0000;
            exp_rd  = v;
            exp_lat = 3; exp_en = 1; exp_we = 0;
        end

        @(negedge clka);
        check("ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr[ADDR_W+1:0];
        req_wdata  = wdata;
        @(posedge clka);
        #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = (ADDR_W+2)'($urandom);
        req_wdata  = $urandom;

        lat = 0; en_cnt = 0; we_cnt = 0; got = 1'b0;
        while (lat < 8 && !got) begin
            @(negedge clka);
            lat++;
            en_cnt += int'(mem_en);
            we_cnt += int'(mem_we);
            if (rsp_valid) got = 1'b1;
        end
        check("rsp_seen", {31'b0, got}, 32'd1);
        check("latency", lat, exp_lat);
        check("rdata", rsp_rdata, exp_rd);
        check("err", {31'b0, rsp_err}, {31'b0, exp_err});
        check("mem_en_cycles", en_cnt, exp_en);
        check("mem_we_cycles", we_cnt, exp_we);
        @(negedge clka);
        check("rsp_pulse", {31'b0, rsp_valid}, 32'd0);
        check("ready_back", {31'b0, req_ready}, 32'd1);
        check("rdata_hold", rsp_rdata, exp_rd);
    endtask

    initial begin
        rsta_n     = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = 32'h0;
        init_en    = 1'b0;
        init_addr  = 6'd0;
        init_data  = 32'h0;

        for (int i = 0; i < NWORDS; i++) begin
            @(negedge clka);
            init_en   = 1'b1;
            init_addr = 6'(i);
            init_data = $urandom;
            model[i]  = init_data;
        end
        @(negedge clka);
        init_en = 1'b0;

        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_err", {31'b0, rsp_err}, 32'd0);
        check("rst_mem_en", {31'b0, mem_en}, 32'd0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_mem_addr", {19'b0, mem_addr}, 32'd0);
        check("rst_mem_din", mem_din, 32'h0);
        rsta_n = 1'b1;
        @(negedge clka);

        run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
        run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check("word_rt", rsp_rdata, 32'hDEAD_BEEF);

        run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344);
        run_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_005A);
        check("rmw_ram", ram[4], 32'h5A22_3344);

        run_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h80FF_7F01);
        run_req(1'b0, 2'b00, 1'b1, 32'h22, 32'h0);
        check("sbyte_22", rsp_rdata, 32'hFFFF_FFFF);
        run_req(1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
        check("uhalf_22", rsp_rdata, 32'h0000_80FF);
        run_req(1'b0, 2'b00, 1'b1, 32'h20, 32'h0);
        check("sbyte_20", rsp_rdata, 32'h0000_0001);
        run_req(1'b0, 2'b01, 1'b0, 32'h21, 32'h0);
`ifdef MISALIGN_TRAP_EN
        check("mis_half_err", {31'b0, rsp_err}, 32'd1);
        check("mis_half_data", rsp_rdata, 32'h0);
`else
        check("mis_half_err", {31'b0, rsp_err}, 32'd0);
        check("mis_half_data", rsp_rdata, 32'h0000_7F01);
`endif

        // Reset during RD_WAIT of a byte store must abort without writing
        @(negedge clka);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = (ADDR_W+2)'(32'h41); req_wdata = 32'h0000_00AB;
        @(posedge clka);
        #1 req_valid = 1'b0;
        @(posedge clka);
        #1 rsta_n = 1'b0;
        #1;
        check("abort_mem_en", {31'b0, mem_en}, 32'd0);
        check("abort_mem_we", {31'b0, mem_we}, 32'd0);
        check("abort_rsp", {31'b0, rsp_valid}, 32'd0);
        repeat (2) begin
            @(negedge clka);
            check("abort_no_rsp", {31'b0, rsp_valid | mem_we}, 32'd0);
        end
        rsta_n = 1'b1;
        repeat (4) begin
            @(negedge clka);
            check("abort_after", {30'b0, rsp_valid, mem_we}, 32'd0);
        end
        check("abort_ready", {31'b0, req_ready}, 32'd1);
        check("abort_ram", ram[16], model[16]);

        for (int t = 0; t < 150; t++) begin
            run_req(1'($urandom), 2'($urandom), 1'($urandom),
                    int'($urandom_range(0, NWORDS * 4 - 1)), $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clka);
        end

        for (int i = 0; i < NWORDS; i++) begin
            check("final_ram", ram[i], model[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, word-address width of the attached data-cache RAM; data width fixed at 32.
REQ-002 SHALL have port clka  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rsta_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port req_valid  input  1  CPU memory-stage request present.
REQ-005 SHALL have port req_ready  output  1  controller can accept a request.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-008 SHALL have port req_signed  input  1  sign-extend sub-word loads.
REQ-009 SHALL have port req_addr  input  ADDR_W+2  byte address; word index = req_addr[ADDR_W+1:2].
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port rsp_rdata  output  32  load result; 0 for stores and errors.
REQ-013 SHALL have port rsp_err  output  1  misaligned-access error, valid with rsp_valid.
REQ-014 SHALL have ports mem_en, mem_we (output 1 each), mem_addr (output ADDR_W), mem_din (output 32), mem_dout (input 32), driving the RAM's ena, wea, addra, dina, douta; RAM read latency is 1 cycle.

Function
REQ-015 SHALL implement FSM states IDLE, RD, RD_WAIT, WR, RESP; req_ready = 1 only in IDLE.
REQ-016 SHALL capture all req_* fields at the accept edge (req_valid & req_ready); later input changes are ignored until the next accept.
REQ-017 SHALL register mem_* outputs; mem_en = 1 only in RD and WR, mem_we = 1 only in WR, mem_addr = captured word index in RD and WR.
REQ-018 Load: IDLE -> RD -> RD_WAIT -> RESP -> IDLE; rsp_valid asserted 3 cycles after accept edge.
REQ-019 Word store: IDLE -> WR -> RESP -> IDLE; mem_din = captured wdata; rsp_valid 2 cycles after accept.
REQ-020 Byte/half store: read-modify-write IDLE -> RD -> RD_WAIT -> WR -> RESP; merge done at RD_WAIT edge, only the addressed lane(s) replaced; rsp_valid 4 cycles after accept.
REQ-021 Lanes little-endian: byte k = bits [8k+7:8k], k = addr[1:0]; half = bits [16h+15:16h], h = addr[1].
REQ-022 Sub-word loads SHALL zero-extend when req_signed = 0, sign-extend from lane MSB when 1; word loads pass mem_dout unchanged.
REQ-023 rsp_valid SHALL be high exactly one cycle (RESP); no response backpressure; rsp_rdata/rsp_err hold until next RESP.
REQ-024 req_valid while not in IDLE SHALL be ignored; requester holds it until accepted.

Reset
REQ-025 rsta_n low SHALL immediately force IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, mem_en = 0, mem_we = 0, mem_addr = 0, mem_din = 0.
REQ-026 Reset mid-operation SHALL abort the access without response; an interrupted RMW SHALL not write if reset asserts before the WR edge.

Configuration
REQ-027 Macro MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 is accepted, makes no RAM access, goes IDLE -> RESP with rsp_err = 1, rsp_rdata = 0 (latency 1).
REQ-028 MISALIGN_TRAP_EN undefined: offending low address bits are ignored (half uses addr[1] only, word ignores addr[1:0]); rsp_err is constant 0.

Verification
REQ-029 Word store 0xDEADBEEF @0x0010, then unsigned word load @0x0010 -> rsp_rdata 0xDEADBEEF, rsp_valid 2 and 3 cycles after respective accepts.
REQ-030 Byte store 0x5A @0x0013 over word 0x11223344 -> RAM word 0x5A223344 in 4 cycles; mem_we high exactly one cycle.
REQ-031 Word 0x80FF7F01 @0x0020: signed byte load @0x0022 -> 0xFFFFFFFF; unsigned half load @0x0022 -> 0x000080FF; signed byte @0x0020 -> 0x00000001.
REQ-032 Half load @0x0021: with MISALIGN_TRAP_EN -> rsp_err 1, rsp_rdata 0, mem_en never high; without -> rsp_err 0, data of half @0x0020.
REQ-033 Assert rsta_n low during RD_WAIT of a byte store -> mem_en/mem_we low same cycle, no rsp_valid, RAM word unchanged, req_ready 1 after release.
